sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 101 ++++++++++
 tb/tb_sync_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO over a registered-read dual-port RAM.
// Optional build macro SYNC_FIFO_LEVEL_EN adds a registered occupancy output "level".

// dual_port_ram: synchronous write, 1-cycle registered read (old data on same-address collision), contents never reset
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // write port and registered read port share the clock
    always_ff @(posedge clk) begin
        if (we) mem[write_address] <= data_i;
        data_o <= mem[read_address];
    end
endmodule

module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wptr, rptr, rptr_nxt;
    logic [ADDR_WIDTH:0]   count, count_nxt, rem;
    logic                  push, pop, byp_nxt, sel;
    logic [DATA_WIDTH-1:0] ram_q, byp_q;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign rptr_nxt  = rptr + ADDR_WIDTH'(pop);
    assign count_nxt = count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    // words already in RAM before this edge that survive the pop; their head is readable next cycle
    assign rem       = count - (ADDR_WIDTH+1)'(pop);
    // the only word left is being written right now, so the RAM cannot supply it yet: take it from in_data
    assign byp_nxt   = push & pop & (count == (ADDR_WIDTH+1)'(1));
    assign out_data  = out_valid ? (sel ? byp_q : ram_q) : '0;

`ifdef SYNC_FIFO_LEVEL_EN
    assign level = count;
`endif

    // the RAM always prefetches the head that will be current after this edge
    dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk          (clk),
        .we           (push & ~flush),
        .write_address(wptr),
        .read_address (rptr_nxt),
        .data_i       (in_data),
        .data_o       (ram_q)
    );

    // pointers, occupancy, handshake flags and the bypass word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            sel       <= 1'b0;
            byp_q     <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            sel       <= 1'b0;
        end else begin
            wptr      <= wptr + ADDR_WIDTH'(push);
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            out_valid <= (rem != '0) | byp_nxt;
            in_ready  <= count_nxt < (ADDR_WIDTH+1)'(DEPTH);
            sel       <= byp_nxt;
            if (push) byp_q <= in_data;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    localparam int DW = 8, AW = 2, DEPTH = 4;

    logic          clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int checks = 0, errors = 0;
    int q[$], qt[$];
    int cyc = 0;
    bit popped_last = 0, hold = 1;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef SYNC_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    // reference model: a word is visible two cycles after its push, or immediately after a pop that leaves it at the head
    function automatic bit exp_ov();
        if (q.size() == 0) return 0;
        return popped_last || (cyc - qt[0] >= 2);
    endfunction

    function automatic bit exp_ir();
        return !hold && q.size() < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        qt.delete();
        popped_last = 0;
        hold = 1;
    endtask

    task automatic advance();
        bit pu, po;
        int d;
        pu = in_valid && exp_ir();
        po = exp_ov() && out_ready;
        d = int'(in_data);
        @(posedge clk);
        #1;
        cyc++;
        hold = 0;
        if (flush) begin
            q.delete();
            qt.delete();
            popped_last = 0;
        end else begin
            if (po) begin
                void'(q.pop_front());
                void'(qt.pop_front());
            end
            if (pu) begin
                q.push_back(d);
                qt.push_back(cyc - 1);
            end
            popped_last = po;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_pre_edge_in_ready got=%b exp=0", in_ready); end
        advance();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
`ifdef SYNC_FIFO_LEVEL_EN
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
    endtask

    task automatic test_latency();
        in_valid = 1; in_data = 8'hA5; out_ready = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
        advance();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid got=%b exp=0", out_valid); end
        advance();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL lat_cycle2 got=%b/%h exp=1/a5", out_valid, out_data); end
        out_ready = 1;
        advance();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle3_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        int got[$];
        out_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_data = 8'(i);
            advance();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        in_data = 8'h05;
        advance();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL fill_head got=%b/%h exp=1/01", out_valid, out_data); end
`ifdef SYNC_FIFO_LEVEL_EN
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got=%0d exp=4", level); end
`endif
        out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) got.push_back(int'(out_data));
            advance();
        end
        out_ready = 0;
        checks++; if (got.size() != 4) begin errors++; $display("FAIL fill_drain_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] != i + 1) begin errors++; $display("FAIL fill_drain_word%0d got=%h exp=%h", i, got[i], i + 1); end
        end
`ifdef SYNC_FIFO_LEVEL_EN
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_level_empty got=%0d exp=0", level); end
`endif
    endtask

    task automatic test_stream();
        int got[$], gotc[$];
        int sent;
        sent = 0;
        out_ready = 1;
        for (int c = 0; c < 24; c++) begin
            in_valid = sent < 16;
            in_data = 8'(sent);
            checks++; if (in_ready !== exp_ir()) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ir()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
            if (out_valid) begin
                got.push_back(int'(out_data));
                gotc.push_back(c);
            end
            if (in_valid && exp_ir()) sent++;
            advance();
        end
        in_valid = 0; out_ready = 0;
        checks++; if (got.size() != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", got.size()); end
        for (int k = 0; k < got.size() && k < 16; k++) begin
            checks++; if (got[k] != k || gotc[k] != k + 2) begin errors++; $display("FAIL stream_word%0d got=%h@%0d exp=%h@%0d", k, got[k], gotc[k], k, k + 2); end
        end
    endtask

    task automatic test_full_pushpop();
        int got[$];
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 8'h10 + 8'(i);
            advance();
        end
        in_valid = 0;
        advance();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_state got=%b/%b exp=0/1", in_ready, out_valid); end
        in_valid = 1; in_data = 8'h77; out_ready = 1;
        advance();
        in_valid = 0; out_ready = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_in_ready got=%b exp=1", in_ready); end
        out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) got.push_back(int'(out_data));
            advance();
        end
        out_ready = 0;
        checks++; if (got.size() != 3) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] != 'h11 + i) begin errors++; $display("FAIL full_pushpop_word%0d got=%h exp=%h", i, got[i], 'h11 + i); end
        end
    endtask

    task automatic test_bypass();
        in_valid = 1; in_data = 8'h3C; out_ready = 0;
        advance();
        in_valid = 0;
        advance();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL bypass_head got=%b/%h exp=1/3c", out_valid, out_data); end
        in_valid = 1; in_data = 8'hC3; out_ready = 1;
        advance();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin errors++; $display("FAIL bypass_next got=%b/%h exp=1/c3", out_valid, out_data); end
        advance();
        out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        bit seen;
        seen = 0;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 8'h21 + 8'(i);
            advance();
        end
        in_valid = 0;
        advance();
        flush = 1; in_valid = 1; in_data = 8'h99;
        advance();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got=%b/%b exp=0/1", out_valid, in_ready); end
`ifdef SYNC_FIFO_LEVEL_EN
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
`endif
        out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen = 1;
            advance();
        end
        out_ready = 0;
        checks++; if (seen) begin errors++; $display("FAIL flush_residue got=1 exp=0"); end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        in_valid = 1; in_data = 8'h61;
        advance();
        in_data = 8'h62;
        advance();
        in_valid = 0;
        advance();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", out_valid); end
        in_valid = 1; in_data = 8'h63;
        #3 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL arst_immediate got=%b/%b/%h exp=0/0/00", out_valid, in_ready, out_data); end
        in_valid = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        advance();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_release got=%b/%b exp=1/0", in_ready, out_valid); end
        in_valid = 1; in_data = 8'h44;
        advance();
        in_valid = 0;
        advance();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h44) begin errors++; $display("FAIL arst_after got=%b/%h exp=1/44", out_valid, out_data); end
        out_ready = 1;
        advance();
        out_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = 8'($urandom);
            out_ready = $urandom_range(0, 3) < (i < 300 ? 1 : 3);
            flush = $urandom_range(0, 39) == 0;
            checks++; if (in_ready !== exp_ir()) begin errors++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, in_ready, exp_ir()); end
            checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL rand_out_valid i=%0d got=%b exp=%b", i, out_valid, exp_ov()); end
            if (exp_ov()) begin
                checks++; if (out_data !== 8'(q[0])) begin errors++; $display("FAIL rand_out_data i=%0d got=%h exp=%h", i, out_data, 8'(q[0])); end
            end
`ifdef SYNC_FIFO_LEVEL_EN
            checks++; if (int'(level) != q.size()) begin errors++; $display("FAIL rand_level i=%0d got=%0d exp=%0d", i, level, q.size()); end
`endif
            advance();
        end
        in_valid = 0; out_ready = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_stream();
        test_full_pushpop();
        test_bypass();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
